icache_axi_line_fetch: RTL
==========================

Name: icache_axi_line_fetch

Overview:
- Memory-side engine for the instruction cache refill controller.
- Accepts one line-refill request (single req/addr_ok handshake) and issues one AXI4 INCR read burst of LINE_WORDS beats.
- Returns the line word by word on a data_ok/rdata beat stream, in ascending word order from word 0.
- Sits between the refill controller's mem_req/mem_addr_ok/mem_data_ok/mem_rdata port and the AXI read channels of the CPU bus interface.

Parameters:
- LINE_WORDS, 8, words per cache line; power of two, 2..16.
- AXI_ID, 0, 4-bit constant driven on arid.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  refill request from the cache controller.
- addr  in  32  refill address; any byte within the target line.
- addr_ok  out  1  request accepted this cycle.
- data_ok  out  1  one line word valid on rdata this cycle.
- rdata  out  32  returned word.
- busy  out  1  high from acceptance until the last data_ok.
- err  out  1  sticky bus error flag.
- err_clr  in  1  clears err.
- arid  out  4  read address ID.
- araddr  out  32  read address.
- arlen  out  8  burst length minus one.
- arsize  out  3  beat size.
- arburst  out  2  burst type.
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- rid  in  4  read ID; ignored.
- axi_rdata  in  32  read data.
- rresp  in  2  read response.
- rlast  in  1  last beat.
- rvalid  in  1  read data valid.
- rready  out  1  read data ready.

Behaviour:
- Reset values (async, immediate): state=IDLE, addr_ok=0, data_ok=0, rdata=0, busy=0, err=0, arvalid=0, rready=0, araddr=0, beat counter=0.
- Constant outputs: arid=AXI_ID, arlen=LINE_WORDS-1, arsize=3'b010, arburst=2'b01.
- States: IDLE, AR, R, FLUSH.
- IDLE:
  - addr_ok = req, combinational, asserted only in IDLE.
  - On clock edge with req=1: araddr <= addr with low log2(LINE_WORDS)+2 bits cleared; arvalid <= 1; busy <= 1; counter <= 0; go to AR.
- AR:
  - arvalid held high, araddr held stable until the arready handshake.
  - On arvalid & arready: arvalid <= 0, rready <= 1, go to R.
  - req is ignored in every state except IDLE.
- R:
  - rready=1. Each rvalid beat, registered with 1-cycle latency: next cycle data_ok=1 and rdata=axi_rdata of that beat.
  - Counter increments per beat, modulo LINE_WORDS.
  - data_ok is a single-cycle pulse per beat; back-to-back beats give consecutive data_ok cycles.
  - Normal completion: the beat with counter==LINE_WORDS-1 and rlast=1. On that edge rready <= 0, busy <= 0, go to IDLE. Its data_ok appears in the first IDLE cycle.
  - A new req may be accepted in that same IDLE cycle.
  - rresp != 2'b00 on any beat: err <= 1. The beat is still delivered and the burst continues.
- Length mismatch:
  - rlast=1 with counter < LINE_WORDS-1: err <= 1. Zero words are delivered for the missing positions so the consumer always sees exactly LINE_WORDS data_ok pulses.
  - Pad pulses are emitted one per cycle in FLUSH, rdata=0; then go to IDLE.
  - counter==LINE_WORDS-1 with rlast=0: err <= 1. That beat is delivered, then stay in R with rready=1 and discard further beats without data_ok until the rlast beat, then go to IDLE.
  - busy stays high throughout; in this discard case busy is cleared on the edge the rlast beat is accepted.
- err: set per the rules above. err_clr=1 clears it; a set event on the same edge wins over err_clr.
- Reset mid-burst: immediately returns to reset values. Outstanding AXI beats are not tracked; the system asserts reset on the AXI side simultaneously.
- No combinational path from any AXI input to any output. addr_ok depends only on req and state.

Test Plan:
- Basic refill: req with addr=0x1FC0_0014, arready=1 after 2 cycles, 8 consecutive rvalid beats 0xA0..0xA7 with rlast on the 8th. Expect addr_ok one cycle; araddr=0x1FC0_0000, arlen=7; data_ok 8 consecutive cycles, each one cycle after its beat, rdata=0xA0..0xA7; busy low after the last pulse; err=0.
- Gapped R channel: rvalid toggling 1,0,0,1,... across 8 beats. Expect exactly 8 data_ok pulses matching the beat timing; arvalid stays low after the handshake.
- arready stall 10 cycles. Expect arvalid and araddr stable for all 10 cycles; req pulses during the stall produce no addr_ok.
- Early rlast on beat 5. Expect err=1; words 0..4 delivered, then 3 data_ok pulses with rdata=0; return to IDLE.
- SLVERR (rresp=2'b10) on beat 3. Expect err=1, all 8 words delivered; err_clr clears err; err_clr on the same edge as a new error leaves err=1.
- Reset asserted in R after beat 4. Expect all outputs immediately 0; a next req is accepted normally and completes a fresh 8-word burst.

Source files
------------

// File: rtl/icache_axi_line_fetch.sv
// I-cache line refill engine: one req -> one AXI4 INCR burst of LINE_WORDS beats; data_ok/rdata one cycle after each R beat.
// Backpressure: addr_ok only in IDLE; R channel always ready while in R, so rvalid gaps simply delay data_ok.
module icache_axi_line_fetch #(
  parameter int unsigned LINE_WORDS = 8,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err,
  input  logic        err_clr,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  localparam int unsigned CW   = $clog2(LINE_WORDS);
  localparam int unsigned OFF  = CW + 2;
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, AR, R, FLUSH} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          drop, drop_nx;
  logic          data_ok_nx, busy_nx, err_nx, arvalid_nx, rready_nx, err_set;
  logic [31:0]   rdata_nx, araddr_nx;
  logic          unused_in;

  assign unused_in = ^{rid, addr[OFF-1:0]};

  assign arid    = AXI_ID;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign addr_ok = req && (state == IDLE);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    drop_nx    = drop;
    data_ok_nx = 1'b0;
    rdata_nx   = rdata;
    busy_nx    = busy;
    arvalid_nx = arvalid;
    rready_nx  = rready;
    araddr_nx  = araddr;
    err_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          araddr_nx  = {addr[31:OFF], {OFF{1'b0}}};
          arvalid_nx = 1'b1;
          busy_nx    = 1'b1;
          cnt_nx     = '0;
          drop_nx    = 1'b0;
          state_nx   = AR;
        end
      end
      AR: begin
        if (arready) begin
          arvalid_nx = 1'b0;
          rready_nx  = 1'b1;
          state_nx   = R;
        end
      end
      R: begin
        if (rvalid) begin
          if (rresp != 2'b00) err_set = 1'b1;
          if (drop) begin
            // Overlong burst: swallow surplus beats until rlast.
            if (rlast) begin
              rready_nx = 1'b0;
              busy_nx   = 1'b0;
              state_nx  = IDLE;
            end
          end else begin
            data_ok_nx = 1'b1;
            rdata_nx   = axi_rdata;
            cnt_nx     = cnt + 1'b1;
            if (cnt == LAST) begin
              if (rlast) begin
                rready_nx = 1'b0;
                busy_nx   = 1'b0;
                state_nx  = IDLE;
              end else begin
                err_set = 1'b1;
                drop_nx = 1'b1;
              end
            end else if (rlast) begin
              err_set   = 1'b1;
              rready_nx = 1'b0;
              state_nx  = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        // Zero-pad the missing words so the consumer always sees a full line.
        data_ok_nx = 1'b1;
        rdata_nx   = '0;
        cnt_nx     = cnt + 1'b1;
        if (cnt == LAST) begin
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    err_nx = err_set ? 1'b1 : (err_clr ? 1'b0 : err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      drop    <= 1'b0;
      data_ok <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      araddr  <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      drop    <= drop_nx;
      data_ok <= data_ok_nx;
      rdata   <= rdata_nx;
      busy    <= busy_nx;
      err     <= err_nx;
      arvalid <= arvalid_nx;
      rready  <= rready_nx;
      araddr  <= araddr_nx;
    end
  end
endmodule
